osd_char_renderer: RTL and testbench

OSD_CHAR_RENDERER -- requirements
Module: osd_char_renderer

---
 rtl/osd_char_renderer_if.sv | 18 +
 rtl/osd_char_renderer.sv | 110 +++++++++++
 tb/tb_osd_char_renderer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/osd_char_renderer_if.sv
// rtl/osd_char_renderer_if.sv - character VRAM and font ROM read bus of the OSD renderer
interface osd_char_renderer_if;
  logic [15:0] vram_rd_addr;
  logic        vram_rd_en;
  logic [7:0]  vram_rd_data;
  logic [9:0]  font_addr;
  logic [7:0]  font_data;

  modport master (
    output vram_rd_addr, vram_rd_en, font_addr,
    input  vram_rd_data, font_data
  );

  modport slave (
    input  vram_rd_addr, vram_rd_en, font_addr,
    output vram_rd_data, font_data
  );
endinterface

// File: rtl/osd_char_renderer.sv
// rtl/osd_char_renderer.sv - three-stage text OSD pixel pipeline (cell fetch, font fetch, bit select)
module osd_char_renderer #(
  parameter int COLS = 40,
  parameter int ROWS = 30
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       osd_en,
  input  logic [9:0]                 px_x,
  input  logic [9:0]                 px_y,
  input  logic [9:0]                 win_x,
  input  logic [9:0]                 win_y,
  input  logic [15:0]                vram_base,
  input  logic [2:0]                 sync_in,
  osd_char_renderer_if.master        mem,
  output logic                       pix_on,
  output logic                       pix_in_win,
  output logic [2:0]                 sync_out
);

  localparam logic [10:0] WIN_W = 11'(8 * COLS);
  localparam logic [10:0] WIN_H = 11'(8 * ROWS);

  logic        hit0;
  logic [9:0]  dx0, dy0;
  logic [15:0] addr0;

  logic [15:0] addr_hold_q, addr_hold_d;
  logic        hit1_q, hit1_d;
  logic [2:0]  dx1_q, dx1_d;
  logic [2:0]  dy1_q, dy1_d;
  logic [2:0]  sync1_q, sync1_d;
  logic        hit2_q, hit2_d;
  logic        inv2_q, inv2_d;
  logic [2:0]  dx2_q, dx2_d;
  logic [2:0]  sync2_q, sync2_d;
  logic        pix_on_q, pix_on_d;
  logic        pix_in_win_q, pix_in_win_d;
  logic [2:0]  sync_out_q, sync_out_d;

  // S0: 11-bit window compare so an edge past 1023 never wraps into a false hit
  always_comb begin
    hit0 = osd_en
        && ({1'b0, px_x} >= {1'b0, win_x}) && ({1'b0, px_x} < ({1'b0, win_x} + WIN_W))
        && ({1'b0, px_y} >= {1'b0, win_y}) && ({1'b0, px_y} < ({1'b0, win_y} + WIN_H));
    dx0   = px_x - win_x;
    dy0   = px_y - win_y;
    addr0 = vram_base + 16'(dy0 >> 3) * 16'(COLS) + 16'(dx0 >> 3);

    addr_hold_d      = hit0 ? addr0 : addr_hold_q;
    mem.vram_rd_addr = rst ? 16'h0000 : addr_hold_d;
    mem.vram_rd_en   = hit0 & ~rst;

    hit1_d  = hit0;
    dx1_d   = dx0[2:0];
    dy1_d   = dy0[2:0];
    sync1_d = sync_in;
  end

  // S1: the character code arrives now; bit 7 selects inverse video
  always_comb begin
    mem.font_addr = hit1_q ? {mem.vram_rd_data[6:0], dy1_q} : 10'd0;
    hit2_d  = hit1_q;
    inv2_d  = mem.vram_rd_data[7];
    dx2_d   = dx1_q;
    sync2_d = sync1_q;
  end

  // S2: bit 7 of the font row is the leftmost pixel of the cell
  always_comb begin
    pix_on_d     = hit2_q & (mem.font_data[3'd7 - dx2_q] ^ inv2_q);
    pix_in_win_d = hit2_q;
    sync_out_d   = sync2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_hold_q  <= '0;
      hit1_q       <= 1'b0;
      dx1_q        <= '0;
      dy1_q        <= '0;
      sync1_q      <= '0;
      hit2_q       <= 1'b0;
      inv2_q       <= 1'b0;
      dx2_q        <= '0;
      sync2_q      <= '0;
      pix_on_q     <= 1'b0;
      pix_in_win_q <= 1'b0;
      sync_out_q   <= '0;
    end else begin
      addr_hold_q  <= addr_hold_d;
      hit1_q       <= hit1_d;
      dx1_q        <= dx1_d;
      dy1_q        <= dy1_d;
      sync1_q      <= sync1_d;
      hit2_q       <= hit2_d;
      inv2_q       <= inv2_d;
      dx2_q        <= dx2_d;
      sync2_q      <= sync2_d;
      pix_on_q     <= pix_on_d;
      pix_in_win_q <= pix_in_win_d;
      sync_out_q   <= sync_out_d;
    end
  end

  assign pix_on     = pix_on_q;
  assign pix_in_win = pix_in_win_q;
  assign sync_out   = sync_out_q;

endmodule

// File: tb/tb_osd_char_renderer.sv
// tb/tb_osd_char_renderer.sv - bench for osd_char_renderer with VRAM/font models and reference model
module tb_osd_char_renderer;
  localparam int COLS = 40;
  localparam int ROWS = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        osd_en;
  logic [9:0]  px_x, px_y, win_x, win_y;
  logic [15:0] vram_base;
  logic [2:0]  sync_in;
  logic        pix_on, pix_in_win;
  logic [2:0]  sync_out;

  osd_char_renderer_if mem ();

  osd_char_renderer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk        (clk),
    .rst        (rst),
    .osd_en     (osd_en),
    .px_x       (px_x),
    .px_y       (px_y),
    .win_x      (win_x),
    .win_y      (win_y),
    .vram_base  (vram_base),
    .sync_in    (sync_in),
    .mem        (mem),
    .pix_on     (pix_on),
    .pix_in_win (pix_in_win),
    .sync_out   (sync_out)
  );

  logic [7:0] vram [65536];
  logic [7:0] font [1024];

  // synchronous memories: data one clock after strobe/address
  always @(posedge clk) begin
    if (mem.vram_rd_en) mem.vram_rd_data <= vram[mem.vram_rd_addr];
    mem.font_data <= font[mem.font_addr];
  end

  typedef struct packed {logic on; logic win; logic [2:0] sync;} out_t;
  typedef struct {bit rst; bit en; logic [9:0] x, y, wx, wy; logic [15:0] base; logic [2:0] sync;} in_t;
  typedef struct {in_t i; out_t e;} vec_t;

  int n_pass = 0;
  int n_total = 0;
  out_t expq[$];
  logic [15:0] last_addr_m = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic in_t mk(input bit r, input bit en, input int x, input int y,
                             input int wx, input int wy, input int base, input logic [2:0] s);
    in_t v;
    v.rst = r; v.en = en; v.x = 10'(x); v.y = 10'(y);
    v.wx = 10'(wx); v.wy = 10'(wy); v.base = 16'(base); v.sync = s;
    return v;
  endfunction

  function automatic out_t mko(input logic on, input logic win, input logic [2:0] s);
    return out_t'({on, win, s});
  endfunction

  // reference: window test, cell address and glyph bit straight from the arithmetic rules
  function automatic void model(input in_t i, output out_t o, output bit hit, output logic [15:0] addr);
    int dx, dy;
    logic [7:0] code, bits;
    hit = i.en && (int'(i.x) >= int'(i.wx)) && (int'(i.x) < int'(i.wx) + 8 * COLS)
               && (int'(i.y) >= int'(i.wy)) && (int'(i.y) < int'(i.wy) + 8 * ROWS);
    dx = int'(i.x) - int'(i.wx);
    dy = int'(i.y) - int'(i.wy);
    addr = 16'h0000;
    o = '0;
    o.sync = i.sync;
    if (hit) begin
      addr = 16'((int'(i.base) + (dy / 8) * COLS + dx / 8) % 65536);
      code = vram[addr];
      bits = font[{code[6:0], 3'(dy % 8)}];
      o.on = bits[7 - (dx % 8)] ^ code[7];
      o.win = 1'b1;
    end
  endfunction

  task automatic tick(input in_t i, input bit use_tab, input out_t e_tab);
    out_t m, e, got;
    bit hit;
    logic [15:0] addr;
    @(posedge clk);
    #1;
    rst = i.rst; osd_en = i.en; px_x = i.x; px_y = i.y;
    win_x = i.wx; win_y = i.wy; vram_base = i.base; sync_in = i.sync;
    model(i, m, hit, addr);
    e = use_tab ? e_tab : m;
    if (i.rst) begin
      e = '0;
      for (int k = 1; k < expq.size(); k++) expq[k] = '0;
      if (expq.size() == 1) expq[0] = '0;
    end
    expq.push_back(e);
    @(negedge clk);
    if (!i.rst) begin
      check("vram_rd_en", mem.vram_rd_en, hit);
      check("vram_rd_addr", mem.vram_rd_addr, hit ? addr : last_addr_m);
      if (hit) last_addr_m = addr;
    end else begin
      last_addr_m = 16'h0000;
    end
    if (expq.size() > 3) begin
      got = {pix_on, pix_in_win, sync_out};
      e = expq.pop_front();
      check("pix_on", got.on, e.on);
      check("pix_in_win", got.win, e.win);
      check("sync_out", got.sync, e.sync);
    end
  endtask

  vec_t tab[$];
  logic [7:0] a_seq   = 8'b0001_1000;
  logic [7:0] inv_seq = 8'b1110_0111;

  initial begin
    int wx, wy, base;
    rst = 1'b1; osd_en = 1'b0; px_x = '0; px_y = '0; win_x = '0; win_y = '0;
    vram_base = '0; sync_in = '0;
    for (int k = 0; k < 65536; k++) vram[k] = 8'($urandom);
    for (int k = 0; k < 1024; k++) font[k] = 8'($urandom);
    vram[16'h1000] = 8'h41;
    vram[16'h1001] = 8'hC1;
    vram[16'h14AF] = 8'h05;
    vram[16'h03AF] = 8'h05;
    font[{7'h41, 3'd0}] = 8'h18;
    font[{7'h05, 3'd7}] = 8'h01;

    for (int k = 0; k < 4; k++) tick(mk(1, 1, k, 0, 0, 0, 'h1000, 3'b111), 0, '0);
    check("reset_pix_on", pix_on, 1'b0);
    check("reset_pix_in_win", pix_in_win, 1'b0);
    check("reset_sync_out", sync_out, 3'b000);
    check("reset_vram_rd_en", mem.vram_rd_en, 1'b0);
    check("reset_vram_rd_addr", mem.vram_rd_addr, 16'h0000);
    check("reset_font_addr", mem.font_addr, 10'd0);

    // glyph 'A', inverse 'A', alternating sync, last cell, right edge, wrapped base
    for (int k = 0; k < 8; k++)
      tab.push_back('{mk(0, 1, k, 0, 0, 0, 'h1000, (k % 2) ? 3'b010 : 3'b101),
                      mko(a_seq[7 - k], 1'b1, (k % 2) ? 3'b010 : 3'b101)});
    for (int k = 0; k < 8; k++)
      tab.push_back('{mk(0, 1, 8 + k, 0, 0, 0, 'h1000, 3'b000), mko(inv_seq[7 - k], 1'b1, 3'b000)});
    tab.push_back('{mk(0, 1, 319, 239, 0, 0, 'h1000, 3'b001), mko(1'b1, 1'b1, 3'b001)});
    tab.push_back('{mk(0, 1, 320, 239, 0, 0, 'h1000, 3'b110), mko(1'b0, 1'b0, 3'b110)});
    tab.push_back('{mk(0, 1, 319, 239, 0, 0, 'hFF00, 3'b011), mko(1'b1, 1'b1, 3'b011)});
    tab.push_back('{mk(0, 0, 5, 5, 0, 0, 'h1000, 3'b100), mko(1'b0, 1'b0, 3'b100)});
    foreach (tab[k]) tick(tab[k].i, 1, tab[k].e);

    tick(mk(0, 1, 0, 0, 0, 0, 'h1000, 3'b000), 0, '0);
    check("first_cell_addr", mem.vram_rd_addr, 16'h1000);
    tick(mk(0, 1, 319, 239, 0, 0, 'h1000, 3'b000), 0, '0);
    check("last_cell_addr", mem.vram_rd_addr, 16'h14AF);
    tick(mk(0, 1, 319, 239, 0, 0, 'hFF00, 3'b000), 0, '0);
    check("wrap_cell_addr", mem.vram_rd_addr, 16'h03AF);

    // osd_en dropped mid-line
    for (int k = 0; k < 10; k++)
      tick(mk(0, (k < 5), 100 + k, 40, 90, 30, 'h2000, 3'(k)), 0, '0);
    // one-clock reset with hits in flight
    for (int k = 0; k < 10; k++)
      tick(mk((k == 4), 1, 100 + k, 41, 90, 30, 'h2000, 3'(k + 1)), 0, '0);

    wx = 0; wy = 0; base = 0;
    for (int n = 0; n < 400; n++) begin
      if (n % 50 == 0) begin
        wx = $urandom_range(0, 1000);
        wy = $urandom_range(0, 1000);
        base = $urandom_range(0, 65535);
      end
      tick(mk(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) != 0),
              wx + $urandom_range(0, 8 * COLS + 15) - 8,
              wy + $urandom_range(0, 8 * ROWS + 15) - 8,
              wx, wy, base, 3'($urandom)), 0, '0);
    end

    for (int k = 0; k < 3; k++) tick(mk(0, 0, 0, 0, 0, 0, 0, 3'b000), 0, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
